// File: rtl/sub_pp2_if.sv
// sub_pp2_if: operand/result stream bundle for the sub_pp2 pipelined subtractor.
//   master: drives I_a, I_b, I_vld (upstream side) and I_rdy (downstream side),
//           observes O_rdy, O_dout, O_neg, O_vld.
//   slave : the subtractor itself.
interface sub_pp2_if #(
  parameter int unsigned C_IN1 = 12,
  parameter int unsigned C_IN2 = 12,
  parameter int unsigned C_OUT = 13
);
  logic [C_IN1-1:0] I_a;
  logic [C_IN2-1:0] I_b;
  logic             I_vld;
  logic             O_rdy;
  logic [C_OUT-1:0] O_dout;
  logic             O_neg;
  logic             O_vld;
  logic             I_rdy;

  modport master (
    output I_a, I_b, I_vld, I_rdy,
    input  O_rdy, O_dout, O_neg, O_vld
  );

  modport slave (
    input  I_a, I_b, I_vld, I_rdy,
    output O_rdy, O_dout, O_neg, O_vld
  );
endinterface

// File: rtl/sub_pp2.sv
// sub_pp2: two-stage pipelined subtractor, O_dout = I_a - I_b, with valid/ready
// flow control. Stage 1 subtracts the low halves and captures the borrow; stage 2
// subtracts the high halves minus that borrow and registers the full result.
// Ports:
//   I_clk   : clock, rising edge
//   I_rst_n : synchronous reset, active low
//   bus     : sub_pp2_if.slave (I_a, I_b, I_vld, O_rdy, O_dout, O_neg, O_vld, I_rdy)
module sub_pp2 #(
  parameter int unsigned C_IN1    = 12,
  parameter int unsigned C_IN2    = 12,
  parameter int unsigned C_OUT    = 13,
  parameter bit          C_SIGNED = 1'b0
) (
  input  logic     I_clk,
  input  logic     I_rst_n,
  sub_pp2_if.slave bus
);

  localparam int unsigned C_INM = (C_IN1 > C_IN2) ? C_IN1 : C_IN2;
  localparam int unsigned C_IN  = C_INM + (C_INM % 2);
  localparam int unsigned C_I   = C_IN / 2;
  localparam int unsigned C_H1  = C_I + 1;
  localparam int unsigned C_R   = C_IN + 1;

  // Operands extended to the common even width
  logic [C_IN-1:0] a_ext;
  logic [C_IN-1:0] b_ext;

  // Pipeline state
  logic           v1_q, v1_d;
  logic [C_I-1:0] ha_q, ha_d;
  logic [C_I-1:0] hb_q, hb_d;
  logic           bl_q, bl_d;
  logic [C_I-1:0] lsum_q, lsum_d;
  logic           v2_q, v2_d;
  logic [C_R-1:0] r_q, r_d;

  // Combinational helpers
  logic            adv1_c;
  logic            adv2_c;
  logic            in_xfer_c;
  logic [C_H1-1:0] lo_diff_c;
  logic [C_H1-1:0] ha_x_c;
  logic [C_H1-1:0] hb_x_c;
  logic [C_H1-1:0] hi_diff_c;

  // Operand extension to C_IN bits
  always_comb begin
    if (C_SIGNED) begin
      a_ext = C_IN'($signed(bus.I_a));
      b_ext = C_IN'($signed(bus.I_b));
    end else begin
      a_ext = C_IN'(bus.I_a);
      b_ext = C_IN'(bus.I_b);
    end
  end

  // Low-half subtract; the extra top bit is set exactly when a borrow occurs
  always_comb begin
    lo_diff_c = {1'b0, a_ext[C_I-1:0]} - {1'b0, b_ext[C_I-1:0]};
  end

  // High-half subtract on the stage-1 registers, one bit wider so it never wraps
  always_comb begin
    if (C_SIGNED) begin
      ha_x_c = {ha_q[C_I-1], ha_q};
      hb_x_c = {hb_q[C_I-1], hb_q};
    end else begin
      ha_x_c = {1'b0, ha_q};
      hb_x_c = {1'b0, hb_q};
    end
    hi_diff_c = ha_x_c - hb_x_c - C_H1'(bl_q);
  end

  // Flow control: each stage moves when the one after it can take its beat,
  // so a bubble in either stage lets a new beat in even while the output stalls
  always_comb begin
    adv2_c    = !v2_q || bus.I_rdy;
    adv1_c    = adv2_c || !v1_q;
    in_xfer_c = bus.I_vld && adv1_c;
  end

  // Next-state: data registers only load when a valid beat moves into them
  always_comb begin
    v1_d   = v1_q;
    ha_d   = ha_q;
    hb_d   = hb_q;
    bl_d   = bl_q;
    lsum_d = lsum_q;
    v2_d   = v2_q;
    r_d    = r_q;

    if (adv1_c) begin
      v1_d = in_xfer_c;
    end
    if (in_xfer_c) begin
      ha_d   = a_ext[C_IN-1:C_I];
      hb_d   = b_ext[C_IN-1:C_I];
      bl_d   = lo_diff_c[C_I];
      lsum_d = lo_diff_c[C_I-1:0];
    end

    if (adv2_c) begin
      v2_d = v1_q;
    end
    if (adv2_c && v1_q) begin
      r_d = {hi_diff_c, lsum_q};
    end
  end

  // State registers with synchronous reset; reset discards any in-flight beats
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      v1_q   <= 1'b0;
      ha_q   <= '0;
      hb_q   <= '0;
      bl_q   <= 1'b0;
      lsum_q <= '0;
      v2_q   <= 1'b0;
      r_q    <= '0;
    end else begin
      v1_q   <= v1_d;
      ha_q   <= ha_d;
      hb_q   <= hb_d;
      bl_q   <= bl_d;
      lsum_q <= lsum_d;
      v2_q   <= v2_d;
      r_q    <= r_d;
    end
  end

  // Result is truncated or sign-extended to C_OUT; bit C_IN is the sign
  assign bus.O_dout = C_OUT'($signed(r_q));
  assign bus.O_neg  = r_q[C_IN];
  assign bus.O_vld  = v2_q;
  assign bus.O_rdy  = adv1_c;

endmodule

// File: tb/tb_sub_pp2.sv
// tb_sub_pp2: scoreboard bench for sub_pp2. Four instances: 12/12/13 unsigned
// and signed (sharing one stimulus stream), and 11/9 unsigned with C_OUT=12 and
// C_OUT=8 (sharing a second stream). Expected results come from integer arithmetic.
module tb_sub_pp2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint d;
    bit     n;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];
  int   h0 = 0, h1 = 0, h2 = 0, h3 = 0;

  sub_pp2_if #(.C_IN1(12), .C_IN2(12), .C_OUT(13)) if0 ();
  sub_pp2_if #(.C_IN1(12), .C_IN2(12), .C_OUT(13)) if1 ();
  sub_pp2_if #(.C_IN1(11), .C_IN2(9),  .C_OUT(12)) if2 ();
  sub_pp2_if #(.C_IN1(11), .C_IN2(9),  .C_OUT(8))  if3 ();

  assign if1.I_a   = if0.I_a;
  assign if1.I_b   = if0.I_b;
  assign if1.I_vld = if0.I_vld;
  assign if1.I_rdy = if0.I_rdy;
  assign if3.I_a   = if2.I_a;
  assign if3.I_b   = if2.I_b;
  assign if3.I_vld = if2.I_vld;
  assign if3.I_rdy = if2.I_rdy;

  sub_pp2 #(.C_IN1(12), .C_IN2(12), .C_OUT(13), .C_SIGNED(1'b0)) u0 (.I_clk(clk), .I_rst_n(rst_n), .bus(if0));
  sub_pp2 #(.C_IN1(12), .C_IN2(12), .C_OUT(13), .C_SIGNED(1'b1)) u1 (.I_clk(clk), .I_rst_n(rst_n), .bus(if1));
  sub_pp2 #(.C_IN1(11), .C_IN2(9),  .C_OUT(12), .C_SIGNED(1'b0)) u2 (.I_clk(clk), .I_rst_n(rst_n), .bus(if2));
  sub_pp2 #(.C_IN1(11), .C_IN2(9),  .C_OUT(8),  .C_SIGNED(1'b0)) u3 (.I_clk(clk), .I_rst_n(rst_n), .bus(if3));

  // Reference: true integer difference, reduced modulo 2^wo
  function automatic exp_t ref_sub(longint a, longint b, int w1, int w2, int wo, bit sgn);
    exp_t   e;
    longint ea, eb, r;
    ea = a;
    eb = b;
    if (sgn && a >= (longint'(1) << (w1 - 1))) ea = a - (longint'(1) << w1);
    if (sgn && b >= (longint'(1) << (w2 - 1))) eb = b - (longint'(1) << w2);
    r   = ea - eb;
    e.n = (r < 0);
    e.d = r & ((longint'(1) << wo) - 1);
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] pick12();
    case ($urandom % 5)
      0:       return 12'h000;
      1:       return 12'hFFF;
      2:       return 12'h800;
      3:       return 12'h7FF;
      default: return 12'($urandom);
    endcase
  endfunction

  // One clock cycle on stream A; pushes expectations when the beat is accepted
  task automatic cyc_a(input bit vld, input logic [11:0] a, input logic [11:0] b,
                       input bit rdy, output bit acc);
    if0.I_vld = vld;
    if0.I_a   = a;
    if0.I_b   = b;
    if0.I_rdy = rdy;
    @(negedge clk);
    acc = vld && if0.O_rdy && rst_n;
    if (acc) begin
      q0.push_back(ref_sub(longint'(a), longint'(b), 12, 12, 13, 1'b0));
      q1.push_back(ref_sub(longint'(a), longint'(b), 12, 12, 13, 1'b1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input bit vld, input logic [10:0] a, input logic [8:0] b,
                       input bit rdy, output bit acc);
    if2.I_vld = vld;
    if2.I_a   = a;
    if2.I_b   = b;
    if2.I_rdy = rdy;
    @(negedge clk);
    acc = vld && if2.O_rdy && rst_n;
    if (acc) begin
      q2.push_back(ref_sub(longint'(a), longint'(b), 11, 9, 12, 1'b0));
      q3.push_back(ref_sub(longint'(a), longint'(b), 11, 9, 8, 1'b0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [11:0] a, input logic [11:0] b);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 50) begin
      cyc_a(1'b1, a, b, 1'b1, acc);
      n++;
    end
    chk("send_a_accept", longint'(acc), 1);
  endtask

  task automatic send_b(input logic [10:0] a, input logic [8:0] b);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 50) begin
      cyc_b(1'b1, a, b, 1'b1, acc);
      n++;
    end
    chk("send_b_accept", longint'(acc), 1);
  endtask

  // Monitors: O_rdy against beat occupancy, output beats against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      h0 = 0;
    end else begin
      checks++;
      if (if0.O_rdy != (h0 < 2 || if0.I_rdy)) begin
        errors++;
        $display("FAIL rdy0 got %0b want %0b", if0.O_rdy, (h0 < 2 || if0.I_rdy));
      end
      if (if0.O_vld) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL out0 unexpected beat got %0d want none", if0.O_dout);
        end else if (longint'(if0.O_dout) != q0[0].d || if0.O_neg != q0[0].n) begin
          errors++;
          $display("FAIL out0 got %0d neg %0b want %0d neg %0b", if0.O_dout, if0.O_neg, q0[0].d, q0[0].n);
        end
        if (if0.I_rdy && q0.size() != 0) void'(q0.pop_front());
      end
      h0 = h0 + int'(if0.I_vld && if0.O_rdy) - int'(if0.O_vld && if0.I_rdy);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
      h1 = 0;
    end else begin
      checks++;
      if (if1.O_rdy != (h1 < 2 || if1.I_rdy)) begin
        errors++;
        $display("FAIL rdy1 got %0b want %0b", if1.O_rdy, (h1 < 2 || if1.I_rdy));
      end
      if (if1.O_vld) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL out1 unexpected beat got %0d want none", if1.O_dout);
        end else if (longint'(if1.O_dout) != q1[0].d || if1.O_neg != q1[0].n) begin
          errors++;
          $display("FAIL out1 got %0d neg %0b want %0d neg %0b", if1.O_dout, if1.O_neg, q1[0].d, q1[0].n);
        end
        if (if1.I_rdy && q1.size() != 0) void'(q1.pop_front());
      end
      h1 = h1 + int'(if1.I_vld && if1.O_rdy) - int'(if1.O_vld && if1.I_rdy);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q2.delete();
      h2 = 0;
    end else begin
      checks++;
      if (if2.O_rdy != (h2 < 2 || if2.I_rdy)) begin
        errors++;
        $display("FAIL rdy2 got %0b want %0b", if2.O_rdy, (h2 < 2 || if2.I_rdy));
      end
      if (if2.O_vld) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL out2 unexpected beat got %0d want none", if2.O_dout);
        end else if (longint'(if2.O_dout) != q2[0].d || if2.O_neg != q2[0].n) begin
          errors++;
          $display("FAIL out2 got %0d neg %0b want %0d neg %0b", if2.O_dout, if2.O_neg, q2[0].d, q2[0].n);
        end
        if (if2.I_rdy && q2.size() != 0) void'(q2.pop_front());
      end
      h2 = h2 + int'(if2.I_vld && if2.O_rdy) - int'(if2.O_vld && if2.I_rdy);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q3.delete();
      h3 = 0;
    end else begin
      checks++;
      if (if3.O_rdy != (h3 < 2 || if3.I_rdy)) begin
        errors++;
        $display("FAIL rdy3 got %0b want %0b", if3.O_rdy, (h3 < 2 || if3.I_rdy));
      end
      if (if3.O_vld) begin
        checks++;
        if (q3.size() == 0) begin
          errors++;
          $display("FAIL out3 unexpected beat got %0d want none", if3.O_dout);
        end else if (longint'(if3.O_dout) != q3[0].d || if3.O_neg != q3[0].n) begin
          errors++;
          $display("FAIL out3 got %0d neg %0b want %0d neg %0b", if3.O_dout, if3.O_neg, q3[0].d, q3[0].n);
        end
        if (if3.I_rdy && q3.size() != 0) void'(q3.pop_front());
      end
      h3 = h3 + int'(if3.I_vld && if3.O_rdy) - int'(if3.O_vld && if3.I_rdy);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] da [8];
    logic [11:0] db [8];
    logic [11:0] ra, rb;
    logic [10:0] sa;
    logic [8:0]  sb;
    bit          acc;
    bit          have;
    int          idx;

    da = '{12'd30, 12'd64, 12'hF9C, 12'h7FF, 12'h555, 12'h000, 12'h800, 12'hFFF};
    db = '{12'd100, 12'd1, 12'h01E, 12'h800, 12'h555, 12'hFFF, 12'h7FF, 12'h000};

    rst_n = 1'b0;
    if0.I_vld = 1'b0; if0.I_a = '0; if0.I_b = '0; if0.I_rdy = 1'b1;
    if2.I_vld = 1'b0; if2.I_a = '0; if2.I_b = '0; if2.I_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    @(negedge clk);
    chk("rst_vld0",  longint'(if0.O_vld), 0);
    chk("rst_dout0", longint'(if0.O_dout), 0);
    chk("rst_neg0",  longint'(if0.O_neg), 0);
    chk("rst_rdy0",  longint'(if0.O_rdy), 1);
    chk("rst_vld1",  longint'(if1.O_vld), 0);
    chk("rst_vld2",  longint'(if2.O_vld), 0);
    chk("rst_dout3", longint'(if3.O_dout), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two-cycle latency on a single beat: 100 - 30
    cyc_a(1'b1, 12'd100, 12'd30, 1'b1, acc);
    chk("lat_accept", longint'(acc), 1);
    if0.I_vld = 1'b0;
    @(negedge clk);
    chk("lat_vld_c1", longint'(if0.O_vld), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat_vld_c2", longint'(if0.O_vld), 1);
    chk("lat_dout",   longint'(if0.O_dout), 70);
    @(posedge clk);
    #1;

    // Directed vectors, full throughput
    for (int i = 0; i < 8; i++) send_a(da[i], db[i]);
    repeat (4) cyc_a(1'b0, '0, '0, 1'b1, acc);

    // Backpressure: beats 1..4 minus 0 with I_rdy low for cycles 2..5
    idx = 0;
    for (int c = 1; c <= 14; c++) begin
      cyc_a(idx < 4, 12'(idx + 1), 12'd0, !(c >= 2 && c <= 5), acc);
      if (acc) idx++;
    end
    chk("bp_all_sent", longint'(idx), 4);

    // Randomized traffic with random backpressure
    have = 1'b0;
    ra = '0;
    rb = '0;
    for (int i = 0; i < 400; i++) begin
      if (!have) begin
        ra   = pick12();
        rb   = pick12();
        have = ($urandom % 4) != 0;
      end
      cyc_a(have, ra, rb, ($urandom % 3) != 0, acc);
      if (acc) have = 1'b0;
    end
    repeat (6) cyc_a(1'b0, '0, '0, 1'b1, acc);
    chk("drain_q0", longint'(q0.size()), 0);
    chk("drain_q1", longint'(q1.size()), 0);

    // Stream B: odd widths, truncated and non-truncated outputs
    send_b(11'd2047, 9'd511);
    send_b(11'd0, 9'd511);
    send_b(11'd1024, 9'd256);
    send_b(11'd5, 9'd5);
    have = 1'b0;
    sa = '0;
    sb = '0;
    for (int i = 0; i < 200; i++) begin
      if (!have) begin
        sa   = 11'($urandom);
        sb   = 9'($urandom);
        have = ($urandom % 4) != 0;
      end
      cyc_b(have, sa, sb, ($urandom % 3) != 0, acc);
      if (acc) have = 1'b0;
    end
    repeat (6) cyc_b(1'b0, '0, '0, 1'b1, acc);
    chk("drain_q2", longint'(q2.size()), 0);
    chk("drain_q3", longint'(q3.size()), 0);

    // Reset with both stages full and output stalled
    for (int i = 0; i < 5; i++) cyc_a(1'b1, 12'(i + 9), 12'd1, 1'b0, acc);
    chk("stall_full_rdy", longint'(if0.O_rdy), 0);
    if0.I_vld = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_vld",  longint'(if0.O_vld), 0);
    chk("rst2_dout", longint'(if0.O_dout), 0);
    chk("rst2_neg",  longint'(if0.O_neg), 0);
    chk("rst2_rdy",  longint'(if0.O_rdy), 1);
    @(posedge clk);
    #1;
    repeat (8) cyc_a(1'b0, '0, '0, 1'b1, acc);
    send_a(12'd5, 12'd9);
    repeat (4) cyc_a(1'b0, '0, '0, 1'b1, acc);
    chk("final_q0", longint'(q0.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
